// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix FSM state type and ASCII control codes
// for the PS/2 set-2 decoder.
package ps2_pkg;

  // Set-2 scan codes with special meaning to the decoder
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  // ASCII control characters
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  // Prefix tracker: which prefix bytes precede the next code byte
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 make-code to ASCII translation. Letters follow
// shift XOR caps; digits/punctuation follow shift only. Modifier keys are
// not mapped here (hit = 0), the top level handles them.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       shift,
  input  logic       caps,
  input  logic       ext,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [7:0] up_char;   // uppercase letter, or shifted glyph
  logic [7:0] lo_char;   // unshifted glyph
  logic [1:0] kind;      // 0 none, 1 letter, 2 shift pair, 3 fixed

  // Table lookup followed by case/shift selection
  always_comb begin
    up_char = 8'h00;
    lo_char = 8'h00;
    kind    = 2'd0;
    ascii   = 8'h00;
    hit     = 1'b0;
    if (ext) begin
      case (scan_code)
        SC_KP_SLASH: begin lo_char = "/";      kind = 2'd3; end
        SC_ENTER:    begin lo_char = ASCII_CR; kind = 2'd3; end
        default:     kind = 2'd0;
      endcase
    end else begin
      case (scan_code)
        8'h1C: begin up_char = "A"; kind = 2'd1; end
        8'h32: begin up_char = "B"; kind = 2'd1; end
        8'h21: begin up_char = "C"; kind = 2'd1; end
        8'h23: begin up_char = "D"; kind = 2'd1; end
        8'h24: begin up_char = "E"; kind = 2'd1; end
        8'h2B: begin up_char = "F"; kind = 2'd1; end
        8'h34: begin up_char = "G"; kind = 2'd1; end
        8'h33: begin up_char = "H"; kind = 2'd1; end
        8'h43: begin up_char = "I"; kind = 2'd1; end
        8'h3B: begin up_char = "J"; kind = 2'd1; end
        8'h42: begin up_char = "K"; kind = 2'd1; end
        8'h4B: begin up_char = "L"; kind = 2'd1; end
        8'h3A: begin up_char = "M"; kind = 2'd1; end
        8'h31: begin up_char = "N"; kind = 2'd1; end
        8'h44: begin up_char = "O"; kind = 2'd1; end
        8'h4D: begin up_char = "P"; kind = 2'd1; end
        8'h15: begin up_char = "Q"; kind = 2'd1; end
        8'h2D: begin up_char = "R"; kind = 2'd1; end
        8'h1B: begin up_char = "S"; kind = 2'd1; end
        8'h2C: begin up_char = "T"; kind = 2'd1; end
        8'h3C: begin up_char = "U"; kind = 2'd1; end
        8'h2A: begin up_char = "V"; kind = 2'd1; end
        8'h1D: begin up_char = "W"; kind = 2'd1; end
        8'h22: begin up_char = "X"; kind = 2'd1; end
        8'h35: begin up_char = "Y"; kind = 2'd1; end
        8'h1A: begin up_char = "Z"; kind = 2'd1; end
        8'h16: begin lo_char = "1"; up_char = "!"; kind = 2'd2; end
        8'h1E: begin lo_char = "2"; up_char = "@"; kind = 2'd2; end
        8'h26: begin lo_char = "3"; up_char = "#"; kind = 2'd2; end
        8'h25: begin lo_char = "4"; up_char = "$"; kind = 2'd2; end
        8'h2E: begin lo_char = "5"; up_char = "%"; kind = 2'd2; end
        8'h36: begin lo_char = "6"; up_char = "^"; kind = 2'd2; end
        8'h3D: begin lo_char = "7"; up_char = "&"; kind = 2'd2; end
        8'h3E: begin lo_char = "8"; up_char = "*"; kind = 2'd2; end
        8'h46: begin lo_char = "9"; up_char = "("; kind = 2'd2; end
        8'h45: begin lo_char = "0"; up_char = ")"; kind = 2'd2; end
        8'h0E: begin lo_char = 8'h60; up_char = "~"; kind = 2'd2; end
        8'h4E: begin lo_char = "-"; up_char = "_"; kind = 2'd2; end
        8'h55: begin lo_char = "="; up_char = "+"; kind = 2'd2; end
        8'h54: begin lo_char = "["; up_char = "{"; kind = 2'd2; end
        8'h5B: begin lo_char = "]"; up_char = "}"; kind = 2'd2; end
        8'h5D: begin lo_char = 8'h5C; up_char = "|"; kind = 2'd2; end
        8'h4C: begin lo_char = ";"; up_char = ":"; kind = 2'd2; end
        8'h52: begin lo_char = 8'h27; up_char = 8'h22; kind = 2'd2; end
        8'h41: begin lo_char = ","; up_char = "<"; kind = 2'd2; end
        8'h49: begin lo_char = "."; up_char = ">"; kind = 2'd2; end
        8'h4A: begin lo_char = "/"; up_char = "?"; kind = 2'd2; end
        8'h29: begin lo_char = ASCII_SP;  kind = 2'd3; end
        8'h5A: begin lo_char = ASCII_CR;  kind = 2'd3; end
        8'h66: begin lo_char = ASCII_BS;  kind = 2'd3; end
        8'h0D: begin lo_char = ASCII_TAB; kind = 2'd3; end
        8'h76: begin lo_char = ASCII_ESC; kind = 2'd3; end
        default: kind = 2'd0;
      endcase
    end

    case (kind)
      2'd1: begin hit = 1'b1; ascii = (shift ^ caps) ? up_char : up_char + 8'h20; end
      2'd2: begin hit = 1'b1; ascii = shift ? up_char : lo_char; end
      2'd3: begin hit = 1'b1; ascii = lo_char; end
      default: begin hit = 1'b0; ascii = 8'h00; end
    endcase
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 byte stream decoder: prefix tracking, Shift/Caps state,
// ASCII translation and a show-ahead output FIFO with valid/ready.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h2A,
  parameter bit         EMIT_UNKNOWN = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         scan_code,
  input  logic                               scan_valid,
  output logic [7:0]                         ascii_code,
  output logic                               ascii_valid,
  input  logic                               ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               shift_active,
  output logic                               caps_lock,
  output logic                               overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  prefix_state_t state_reg, state_next;
  logic          lshift_reg, rshift_reg, caps_reg, overflow_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic       is_ext, is_make, is_prefix, is_mod;
  logic       push, pop, full, wr_en;
  logic [7:0] push_data, map_ascii;
  logic       map_hit;

  assign is_ext    = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
  assign is_make   = (state_reg == ST_IDLE) || (state_reg == ST_EXT);
  assign is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
  // Extended variants of the modifier codes (e.g. fake shifts) are ignored
  assign is_mod    = !is_ext && ((scan_code == SC_LSHIFT) ||
                                 (scan_code == SC_RSHIFT) ||
                                 (scan_code == SC_CAPS));

  ps2_keymap u_keymap (
    .scan_code (scan_code),
    .shift     (lshift_reg | rshift_reg),
    .caps      (caps_reg),
    .ext       (is_ext),
    .ascii     (map_ascii),
    .hit       (map_hit)
  );

  // Prefix state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next prefix state and character push decision
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_data  = map_hit ? map_ascii : UNKNOWN_CHAR;
    if (scan_valid) begin
      if (scan_code == SC_EXT) begin
        state_next = ST_EXT;
      end else if (scan_code == SC_BREAK) begin
        // F0 after E0 is an extended break; anywhere else it restarts as plain break
        state_next = (state_reg == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        state_next = ST_IDLE;
        push = is_make && !is_mod && (map_hit || (!is_ext && EMIT_UNKNOWN));
      end
    end
  end

  // Modifier state: shift flags follow make/break, caps toggles on make
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_reg <= 1'b0;
      rshift_reg <= 1'b0;
      caps_reg   <= 1'b0;
    end else if (scan_valid && !is_prefix && !is_ext) begin
      if (scan_code == SC_LSHIFT) lshift_reg <= is_make;
      if (scan_code == SC_RSHIFT) rshift_reg <= is_make;
      if (scan_code == SC_CAPS && is_make) caps_reg <= !caps_reg;
    end
  end

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign pop   = (count_reg != '0) && ascii_ready;
  assign wr_en = push && (!full || pop);

  // FIFO storage: write port only, read is show-ahead from the head pointer
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !wr_en) count_reg <= count_reg - 1'b1;
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign ascii_valid  = (count_reg != '0);
  assign ascii_code   = ascii_valid ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_count   = count_reg;
  assign shift_active = lshift_reg | rshift_reg;
  assign caps_lock    = caps_reg;
  assign overflow     = overflow_reg;

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Successor to the single-byte scan-code lookup. Consumes the PS/2 set-2 byte stream from the keyboard receiver and tracks make/break (F0) and extended (E0) prefixes. Maintains Shift and Caps Lock state and emits case-correct ASCII, including shifted punctuation. Output goes through a parametrised FIFO with valid/ready handshake, so downstream consumers (text display, command parser) can stall without losing keystrokes.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2
UNKNOWN_CHAR, 8'h2A, ASCII emitted for unmapped make codes ('*')
EMIT_UNKNOWN, 1, 1 = push UNKNOWN_CHAR for unmapped codes; 0 = drop them

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_code  in  8  byte from PS/2 receiver
scan_valid  in  1  one-cycle strobe; scan_code valid this cycle
ascii_code  out  8  FIFO head character (show-ahead)
ascii_valid  out  1  FIFO non-empty
ascii_ready  in  1  consumer accepts head when ascii_valid & ascii_ready
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
shift_active  out  1  either Shift key held
caps_lock  out  1  Caps Lock toggle state
overflow  out  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block has one clock, clk. While reset is asserted: prefix FSM = IDLE; lshift, rshift, caps_lock, overflow = 0; FIFO empty; ascii_valid = 0; fifo_count = 0; ascii_code = 8'h00.
- Prefix FSM advances only on cycles with scan_valid. It has four states: IDLE, BRK, EXT, EXT_BRK.
- From IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, processed in place, and the FSM stays in IDLE.
- From EXT: F0 -> EXT_BRK; any other byte is an extended make, processed, then -> IDLE.
- From BRK or EXT_BRK: the byte is a break code, processed, then -> IDLE.
- E0 received in BRK, or any prefix byte repeated, is treated as a new prefix: the FSM restarts (E0 -> EXT).
- Modifiers: make 12 sets lshift; make 59 sets rshift; break 12 or 59 clears the matching flag. shift_active = lshift | rshift. Make 58 toggles caps_lock; break 58 does nothing. Modifier codes never push a character.
- Break codes never push a character.
- Typematic repeats (repeated make without a break) push once per make.
- Character translation is done by a combinational keymap:
  - Letters 1C..1A map to A-Z uppercase when shift_active XOR caps_lock, otherwise lowercase (code + 8'h20).
  - Digits and punctuation use the unshifted glyph when shift_active = 0, otherwise the shifted glyph, e.g. 16 -> '1'/'!', 45 -> '0'/')', 4E -> '-'/'_', 52 -> 0x27/'"'. Caps Lock does not affect them.
  - 29 -> 20 (space), 5A -> 0D (enter), 66 -> 08 (backspace), 0D -> 09 (tab), 76 -> 1B (escape).
- Extended makes: E0 4A -> '/' and E0 5A -> 0D. All other extended codes are silently dropped, regardless of EMIT_UNKNOWN.
- Unmapped normal make codes push UNKNOWN_CHAR if EMIT_UNKNOWN = 1, otherwise nothing.
- Latency: a make byte strobed on cycle N is written to the FIFO at the rising edge ending cycle N. It appears on ascii_code with ascii_valid = 1 on cycle N+1 if the FIFO was empty.
- The modifier state used for translation is the state before the current byte.
- FIFO: circular buffer with pointer wrap-around at FIFO_DEPTH; ascii_code is the head entry.
- Pop occurs on ascii_valid & ascii_ready.
- Push and pop in the same cycle are both performed, including when the FIFO is full, in which case count stays at FIFO_DEPTH and nothing is dropped.
- A push while full with no pop is dropped; overflow is set and is cleared only by reset.
- ascii_ready while empty has no effect.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_ENTER=5A, SC_KP_SLASH=4A
  - prefix FSM state enum
  - ASCII control constants CR, BS, TAB, ESC, SP
- Sub-module ps2_keymap (combinational): inputs scan_code, shift, caps, ext; outputs ascii[7:0] and hit. Top-level holds the FSM, modifier registers and FIFO.

Test Plan:
- Stream 1C, F0 1C with ascii_ready=1 -> exactly one 8'h61 ('a'); ascii_valid high for one cycle; fifo_count returns to 0.
- Stream 12, 1C, 16, F0 12, 1C -> 8'h41, 8'h21, 8'h61; shift_active 1 then 0.
- Stream 58, F0 58, 1C, 12, 1C, 16 -> caps_lock=1; outputs 8'h41, 8'h61, 8'h21.
- Stream E0 5A, E0 F0 5A, E0 75, E0 4A -> outputs 8'h0D, 8'h2F only; FSM back in IDLE after each sequence.
- With ascii_ready=0 and FIFO_DEPTH=4, send 5 makes 16,1E,26,25,2E -> fifo_count=4, overflow=1, head 8'h31. Then hold ascii_ready=1 -> drains 31,32,33,34 in order and ascii_valid deasserts.
- Full FIFO, push and pop in the same cycle -> count stays 4, no overflow. Then assert rst_n=0 mid-sequence (after F0) -> all state and outputs clear immediately; the next byte 1C yields 'a'.
